rf68000_nic_initiator: RTL

- Bus-master (initiator) side of the node's NIC port.
- Accepts memory-access requests from the ring-network packet logic over a valid/ready interface and queues them in a small FIFO.
- Issues each request as a single classic Wishbone cycle on the nic_* bus toward the node arbiter.
- Returns read data or a write completion, with tag and error flag, over a valid/ready response interface.

---
 rtl/rf68000_nic_initiator.sv | 116 +++++++++++
 1 files changed

// File: rtl/rf68000_nic_initiator.sv
// rf68000_nic_initiator: queues memory requests in a FIFO and issues each as one
// classic Wishbone cycle, returning data or a timeout error with the request tag.
module rf68000_nic_initiator #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [7:0]  req_tag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_dat,
    output logic [7:0]  resp_tag,
    output logic        resp_err,
    output logic        nic_cyc,
    output logic        nic_stb,
    output logic        nic_we,
    output logic [3:0]  nic_sel,
    output logic [31:0] nic_adr,
    output logic [31:0] nic_dato,
    input  logic        nic_ack,
    input  logic [31:0] nic_dati
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BUS, RESP, GAP} state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [7:0]  tag;
    } req_t;

    req_t          mem_q [FIFO_DEPTH];
    state_t        state_q;
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   tmo_q;
    logic [7:0]    tag_q;
    logic          push, pop;
    req_t          head;

    assign req_ready = cnt_q != (AW+1)'(FIFO_DEPTH);
    assign push      = req_valid && req_ready;
    assign pop       = state_q == IDLE && cnt_q != '0;
    assign cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    assign head      = mem_q[rp_q];

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wp_q] <= '{we: req_we, sel: req_sel, adr: req_adr, dat: req_dat, tag: req_tag};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            tag_q      <= '0;
            nic_cyc    <= 1'b0;
            nic_stb    <= 1'b0;
            nic_we     <= 1'b0;
            nic_sel    <= '0;
            nic_adr    <= '0;
            nic_dato   <= '0;
            resp_valid <= 1'b0;
            resp_dat   <= '0;
            resp_tag   <= '0;
            resp_err   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            case (state_q)
                IDLE: if (pop) begin
                    nic_we   <= head.we;
                    nic_sel  <= head.sel;
                    nic_adr  <= head.adr;
                    nic_dato <= head.dat;
                    tag_q    <= head.tag;
                    nic_cyc  <= 1'b1;
                    nic_stb  <= 1'b1;
                    tmo_q    <= '0;
                    state_q  <= BUS;
                end
                BUS: if (nic_ack || tmo_q == 16'(TIMEOUT - 1)) begin
                    // ack takes priority over an expiring counter on the same edge
                    nic_cyc    <= 1'b0;
                    nic_stb    <= 1'b0;
                    nic_we     <= 1'b0;
                    resp_dat   <= (nic_ack && !nic_we) ? nic_dati : 32'h0;
                    resp_err   <= !nic_ack;
                    resp_tag   <= tag_q;
                    resp_valid <= 1'b1;
                    state_q    <= RESP;
                end else begin
                    tmo_q <= tmo_q + 16'd1;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state_q    <= GAP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
